// File: rtl/universal_range_counter_if.sv
// Control/status bundle for universal_range_counter: window, step, policy and events.
interface universal_range_counter_if #(
  parameter int N = 8
);
  logic         syn_clr;
  logic         load;
  logic         en;
  logic         up;
  logic         mode;
  logic [N-1:0] d;
  logic [N-1:0] lo;
  logic [N-1:0] hi;
  logic [N-1:0] step;
  logic [N-1:0] q;
  logic         max_tick;
  logic         min_tick;
  logic         wrap_pulse;
  logic         sat_pulse;
  logic         cfg_err;

  modport master (
    output syn_clr, load, en, up, mode, d, lo, hi, step,
    input  q, max_tick, min_tick, wrap_pulse, sat_pulse, cfg_err
  );

  modport slave (
    input  syn_clr, load, en, up, mode, d, lo, hi, step,
    output q, max_tick, min_tick, wrap_pulse, sat_pulse, cfg_err
  );
endinterface

// File: rtl/universal_range_counter.sv
// Bounded up/down counter with run-time window [lo, hi], programmable step,
// wrap/saturate edge policy and registered one-cycle event pulses.
module universal_range_counter #(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  universal_range_counter_if.slave bus
);

  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic         sat_q, sat_d;
  logic         cfg_err;
  logic [N:0]   sum;
  logic [N:0]   diff;

  assign cfg_err = (bus.lo > bus.hi);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    sat_d  = 1'b0;
    // One extra bit keeps carry/borrow visible instead of silently wrapping at 2^N.
    sum    = {1'b0, q_q} + {1'b0, bus.step};
    diff   = {1'b0, q_q} - {1'b0, bus.step};
    if (!cfg_err) begin
      if (bus.syn_clr) begin
        q_d = bus.lo;
      end else if (bus.load) begin
        if (bus.d < bus.lo)      q_d = bus.lo;
        else if (bus.d > bus.hi) q_d = bus.hi;
        else                     q_d = bus.d;
      end else if (bus.en && (bus.step != '0)) begin
        if (bus.up) begin
          if (sum > {1'b0, bus.hi}) begin
            if (bus.mode) begin
              q_d   = bus.hi;
              sat_d = 1'b1;
            end else begin
              q_d    = bus.lo;
              wrap_d = 1'b1;
            end
          end else begin
            q_d = sum[N-1:0];
          end
        end else begin
          if (diff[N] || (diff[N-1:0] < bus.lo)) begin
            if (bus.mode) begin
              q_d   = bus.lo;
              sat_d = 1'b1;
            end else begin
              q_d    = bus.hi;
              wrap_d = 1'b1;
            end
          end else begin
            q_d = diff[N-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.q          = q_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.sat_pulse  = sat_q;
  assign bus.max_tick   = (q_q == bus.hi);
  assign bus.min_tick   = (q_q == bus.lo);
  assign bus.cfg_err    = cfg_err;

endmodule

// File: tb/tb_universal_range_counter.sv
// Directed bench for universal_range_counter: hand-computed q/pulse/tick values per edge.
module tb_universal_range_counter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  universal_range_counter_if #(.N(8)) bus ();

  universal_range_counter #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input logic [7:0] eq, input logic ew, input logic es);
    chk({tag, "_q"}, 32'(bus.q), 32'(eq));
    chk({tag, "_wrap"}, 32'(bus.wrap_pulse), 32'(ew));
    chk({tag, "_sat"}, 32'(bus.sat_pulse), 32'(es));
  endtask

  task automatic load_val(input logic [7:0] v);
    bus.en = 1'b0; bus.load = 1'b1; bus.d = v;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    int wraps;
    logic [7:0] exp_q;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.syn_clr = 1'b0; bus.load = 1'b0; bus.en = 1'b0; bus.up = 1'b1; bus.mode = 1'b0;
    bus.d = 8'd0; bus.lo = 8'd0; bus.hi = 8'd255; bus.step = 8'd1;
    #1;
    chk_state("reset", 8'd0, 1'b0, 1'b0);
    chk("reset_min_tick", 32'(bus.min_tick), 32'd1);
    chk("reset_cfg_err", 32'(bus.cfg_err), 32'd0);
    tick();
    rst_n = 1'b1;

    // Reset mid-count
    bus.en = 1'b1;
    repeat (55) tick();
    chk_state("count37", 8'h37, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_state("async_rst", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.en = 1'b0;

    // Wrap up
    bus.lo = 8'd3; bus.hi = 8'd9; bus.step = 8'd2; bus.up = 1'b1; bus.mode = 1'b0;
    load_val(8'd3);
    chk_state("wrap_start", 8'd3, 1'b0, 1'b0);
    bus.en = 1'b1;
    tick(); chk_state("wrap_5", 8'd5, 1'b0, 1'b0);
    tick(); chk_state("wrap_7", 8'd7, 1'b0, 1'b0);
    tick(); chk_state("wrap_9", 8'd9, 1'b0, 1'b0);
    chk("wrap_9_max_tick", 32'(bus.max_tick), 32'd1);
    tick(); chk_state("wrap_3", 8'd3, 1'b1, 1'b0);
    chk("wrap_3_min_tick", 32'(bus.min_tick), 32'd1);
    tick(); chk_state("wrap_after", 8'd5, 1'b0, 1'b0);

    // Saturate down
    bus.lo = 8'd10; bus.hi = 8'd200; bus.step = 8'd7; bus.up = 1'b0; bus.mode = 1'b1;
    load_val(8'd20);
    bus.en = 1'b1;
    tick(); chk_state("sat_13", 8'd13, 1'b0, 1'b0);
    tick(); chk_state("sat_10a", 8'd10, 1'b0, 1'b1);
    chk("sat_min_tick", 32'(bus.min_tick), 32'd1);
    chk("sat_max_tick", 32'(bus.max_tick), 32'd0);
    tick(); chk_state("sat_10b", 8'd10, 1'b0, 1'b1);
    bus.en = 1'b0;
    tick(); chk_state("sat_idle", 8'd10, 1'b0, 1'b0);

    // Priority and clamp
    bus.lo = 8'd4; bus.hi = 8'd100; bus.d = 8'd50; bus.syn_clr = 1'b1; bus.load = 1'b1; bus.en = 1'b1;
    tick(); chk_state("prio_clr", 8'd4, 1'b0, 1'b0);
    bus.syn_clr = 1'b0; bus.en = 1'b0; bus.d = 8'd250;
    tick(); chk_state("clamp_hi", 8'd100, 1'b0, 1'b0);
    chk("clamp_hi_max_tick", 32'(bus.max_tick), 32'd1);
    bus.d = 8'd1;
    tick(); chk_state("clamp_lo", 8'd4, 1'b0, 1'b0);
    bus.d = 8'd77; bus.en = 1'b1; bus.up = 1'b1; bus.step = 8'd1;
    tick(); chk_state("load_over_en", 8'd77, 1'b0, 1'b0);
    bus.load = 1'b0;
    tick(); chk_state("count_78", 8'd78, 1'b0, 1'b0);
    bus.en = 1'b0;

    // Wide step, carry and borrow
    bus.lo = 8'd0; bus.hi = 8'd255; bus.step = 8'd10; bus.up = 1'b1; bus.mode = 1'b0;
    load_val(8'd250);
    bus.en = 1'b1;
    tick(); chk_state("carry_wrap", 8'd0, 1'b1, 1'b0);
    bus.mode = 1'b1;
    load_val(8'd250);
    bus.en = 1'b1;
    tick(); chk_state("carry_sat", 8'd255, 1'b0, 1'b1);
    tick(); chk_state("carry_sat_again", 8'd255, 1'b0, 1'b1);
    bus.up = 1'b0;
    load_val(8'd5);
    bus.en = 1'b1;
    tick(); chk_state("borrow_sat", 8'd0, 1'b0, 1'b1);
    bus.mode = 1'b0;
    load_val(8'd5);
    bus.en = 1'b1;
    tick(); chk_state("borrow_wrap", 8'd255, 1'b1, 1'b0);

    // Config error freezes, step 0 holds
    bus.lo = 8'd50; bus.hi = 8'd40; bus.load = 1'b1; bus.d = 8'd45;
    #1;
    chk("cfg_err_set", 32'(bus.cfg_err), 32'd1);
    tick(); chk_state("cfg_err_frozen", 8'd255, 1'b0, 1'b0);
    bus.load = 1'b0;
    tick(); chk_state("cfg_err_frozen2", 8'd255, 1'b0, 1'b0);
    bus.lo = 8'd0; bus.hi = 8'd255; bus.step = 8'd0; bus.up = 1'b1; bus.mode = 1'b1;
    #1;
    chk("cfg_err_clear", 32'(bus.cfg_err), 32'd0);
    tick(); chk_state("step0_sat", 8'd255, 1'b0, 1'b0);
    bus.mode = 1'b0; bus.up = 1'b0;
    tick(); chk_state("step0_wrap", 8'd255, 1'b0, 1'b0);

    // Window moved below q: up from q > hi is an edge event
    bus.lo = 8'd2; bus.hi = 8'd5; bus.step = 8'd1; bus.up = 1'b1; bus.mode = 1'b0;
    tick(); chk_state("outside_wrap", 8'd2, 1'b1, 1'b0);

    // Periodic wrap every 4 cycles
    wraps = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_q = 8'(2 + ((i + 1) % 4));
      chk($sformatf("period_q%0d", i), 32'(bus.q), 32'(exp_q));
      if (bus.wrap_pulse) wraps++;
    end
    chk("period_wraps", 32'(wraps), 32'd2);
    bus.en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
